// File: rtl/vx_cache_wb_data.sv
// vx_cache_wb_data: writeback bank data store with dirty tracking, one-entry eviction buffer and flush engine.
// Define VX_CACHE_WB_BYTE_DIRTY_EN for per-byte dirty masks; otherwise one dirty bit per line/way.
module vx_cache_wb_data #(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_SIZE  = 16,
  parameter int NUM_BANKS  = 1,
  parameter int NUM_WAYS   = 2,
  parameter int WORD_SIZE  = 4,
  parameter int BANK_ID    = 0,
  localparam int WPL   = LINE_SIZE / WORD_SIZE,
  localparam int LINES = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
  localparam int LSB   = LINES > 1 ? $clog2(LINES) : 1,
  localparam int WAYB  = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1,
  localparam int WSB   = WPL > 1 ? $clog2(WPL) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   read,
  input  logic                   write,
  input  logic                   fill,
  output logic                   fill_ready,
  input  logic [LSB-1:0]         line_sel,
  input  logic [WSB-1:0]         wsel,
  input  logic [WORD_SIZE-1:0]   byteen,
  input  logic [8*WORD_SIZE-1:0] write_data,
  input  logic [8*LINE_SIZE-1:0] fill_data,
  input  logic [NUM_WAYS-1:0]    way_sel,
  output logic [8*WORD_SIZE-1:0] read_data,
  output logic                   line_dirty,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   flush_done,
  output logic                   evict_valid,
  input  logic                   evict_ready,
  output logic [LSB-1:0]         evict_line_sel,
  output logic [WAYB-1:0]        evict_way,
  output logic [8*LINE_SIZE-1:0] evict_data,
  output logic [LINE_SIZE-1:0]   evict_byteen
);
`ifdef VX_CACHE_WB_BYTE_DIRTY_EN
  localparam int DW = LINE_SIZE;
`else
  localparam int DW = 1;
`endif
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [8*LINE_SIZE-1:0] data [LINES][NUM_WAYS];
  logic [DW-1:0] dirty [LINES][NUM_WAYS];
  logic [LSB-1:0] scan_line, addr, ev_line;
  logic [WAYB-1:0] scan_way, way, ev_way;
  logic [8*LINE_SIZE-1:0] ev_data;
  logic [DW-1:0] ev_mask, wmask, cur_mask, scan_mask;
  logic ev_valid, core_ok, fill_go, wr_go, ld_fill, ld_scan, scan_adv, scan_last, way_last;
  always_comb begin
    way = '0;
    for (int i = 0; i < NUM_WAYS; i++) if (way_sel[i]) way = WAYB'(i);
  end
`ifdef VX_CACHE_WB_BYTE_DIRTY_EN
  assign wmask        = DW'(byteen) << (int'(wsel) * WORD_SIZE);
  assign evict_byteen = ev_mask;
`else
  assign wmask        = |byteen;
  assign evict_byteen = {LINE_SIZE{ev_mask}};
`endif
  assign flush_busy     = state != IDLE;
  assign flush_done     = state == DONE;
  assign addr           = flush_busy ? scan_line : line_sel;
  assign core_ok        = ~stall & ~flush_busy;
  assign fill_ready     = ~ev_valid;
  assign fill_go        = fill & core_ok & fill_ready;
  assign wr_go          = write & ~fill & core_ok;
  assign cur_mask       = dirty[addr][way];
  assign scan_mask      = dirty[scan_line][scan_way];
  assign line_dirty     = |cur_mask;
  assign read_data      = data[addr][way][int'(wsel)*8*WORD_SIZE +: 8*WORD_SIZE];
  assign ld_fill        = fill_go & |cur_mask;
  assign ld_scan        = state == SCAN && |scan_mask && !ev_valid;
  assign scan_adv       = state == SCAN && (!(|scan_mask) || !ev_valid);
  assign way_last       = scan_way == WAYB'(NUM_WAYS - 1);
  assign scan_last      = way_last && scan_line == LSB'(LINES - 1);
  assign evict_valid    = ev_valid;
  assign evict_line_sel = ev_line;
  assign evict_way      = ev_way;
  assign evict_data     = ev_data;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = flush_req ? SCAN : IDLE;
      SCAN:    state_n = scan_adv && scan_last ? DRAIN : SCAN;
      DRAIN:   state_n = ev_valid ? DRAIN : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      scan_line <= '0;
      scan_way  <= '0;
      ev_valid  <= 1'b0;
      for (int l = 0; l < LINES; l++)
        for (int w = 0; w < NUM_WAYS; w++) dirty[l][w] <= '0;
    end else begin
      state <= state_n;
      if (scan_adv) begin
        scan_way <= way_last ? '0 : scan_way + WAYB'(1);
        if (way_last) scan_line <= scan_last ? '0 : scan_line + LSB'(1);
      end
      if (ld_fill || ld_scan) ev_valid <= 1'b1;
      else if (evict_ready) ev_valid <= 1'b0;
      if (ld_scan) dirty[scan_line][scan_way] <= '0;
      if (fill_go) dirty[line_sel][way] <= '0;
      else if (wr_go) dirty[line_sel][way] <= dirty[line_sel][way] | wmask;
    end
  end
  // Line storage and eviction payload are never reset; evict_* is qualified by evict_valid.
  always_ff @(posedge clk) begin
    if (ld_fill || ld_scan) begin
      ev_line <= ld_scan ? scan_line : line_sel;
      ev_way  <= ld_scan ? scan_way : way;
      ev_data <= ld_scan ? data[scan_line][scan_way] : data[line_sel][way];
      ev_mask <= ld_scan ? scan_mask : cur_mask;
    end
    if (fill_go) data[line_sel][way] <= fill_data;
    else if (wr_go)
      for (int b = 0; b < WORD_SIZE; b++)
        if (byteen[b]) data[line_sel][way][(int'(wsel)*WORD_SIZE + b)*8 +: 8] <= write_data[b*8 +: 8];
  end
  a_fill_ready: assert property (@(posedge clk) disable iff (reset) fill && !stall && !flush_busy |-> fill_ready)
    else $error("vx_cache_wb_data[%0d]: fill issued while fill_ready=0", BANK_ID);
  a_way_onehot: assert property (@(posedge clk) disable iff (reset) (read || write || fill) && core_ok |-> $onehot(way_sel));
endmodule

// File: tb/tb_vx_cache_wb_data.sv
// tb_vx_cache_wb_data: scoreboard bench for the writeback data store (default build, optional byte-dirty build).
module tb_vx_cache_wb_data;
  localparam int LINES = 32;
  localparam int NW = 2;
  logic clk = 0, reset = 1, stall = 0, read = 0, write = 0, fill = 0, flush_req = 0, evict_ready = 0;
  logic [4:0] line_sel = 0;
  logic [1:0] wsel = 0;
  logic [3:0] byteen = 0;
  logic [31:0] write_data = 0;
  logic [127:0] fill_data = 0;
  logic [1:0] way_sel = 2'b01;
  logic fill_ready, line_dirty, flush_busy, flush_done, evict_valid;
  logic [31:0] read_data;
  logic [4:0] evict_line_sel;
  logic evict_way;
  logic [127:0] evict_data;
  logic [15:0] evict_byteen;
  int checks = 0, failures = 0, done_total = 0, ev_cnt = 0;
  typedef struct {
    logic [4:0] line;
    logic way;
    logic [127:0] data;
    logic [15:0] mask;
  } ev_t;
  ev_t exq[$];
  ev_t mon_e;
  logic [127:0] mdata [LINES][NW];
  logic [15:0] mdirty [LINES][NW];

  vx_cache_wb_data dut (
    .clk(clk), .reset(reset), .stall(stall), .read(read), .write(write), .fill(fill),
    .fill_ready(fill_ready), .line_sel(line_sel), .wsel(wsel), .byteen(byteen),
    .write_data(write_data), .fill_data(fill_data), .way_sel(way_sel), .read_data(read_data),
    .line_dirty(line_dirty), .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_line_sel(evict_line_sel),
    .evict_way(evict_way), .evict_data(evict_data), .evict_byteen(evict_byteen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_mask(input logic [15:0] m);
`ifdef VX_CACHE_WB_BYTE_DIRTY_EN
    return m;
`else
    return (m != 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  // Retirements are popped against the scoreboard in handshake order.
  always @(negedge clk) begin
    if (flush_done) done_total++;
    if (!reset && evict_valid && evict_ready) begin
      check("ev_pending", exq.size() != 0, 1);
      if (exq.size() != 0) begin
        mon_e = exq.pop_front();
        check("ev_line", evict_line_sel, mon_e.line);
        check("ev_way", evict_way, mon_e.way);
        check("ev_data", evict_data, mon_e.data);
        check("ev_byteen", evict_byteen, mon_e.mask);
        ev_cnt++;
      end
    end
  end

  task automatic sel(input int l, input int w, input int ws);
    line_sel = 5'(l);
    way_sel = 2'(1 << w);
    wsel = 2'(ws);
  endtask

  task automatic wr(input int l, input int w, input int ws, input logic [3:0] be, input logic [31:0] d, input bit accepted);
    sel(l, w, ws);
    write = 1; byteen = be; write_data = d;
    @(posedge clk); #1 write = 0;
    if (accepted) begin
      for (int b = 0; b < 4; b++) if (be[b]) mdata[l][w][(ws*4 + b)*8 +: 8] = d[b*8 +: 8];
      mdirty[l][w] = mdirty[l][w] | (16'(be) << (ws*4));
    end
  endtask

  task automatic fl(input int l, input int w, input logic [127:0] d);
    sel(l, w, 0);
    if (mdirty[l][w] != 0) exq.push_back('{5'(l), 1'(w), mdata[l][w], exp_mask(mdirty[l][w])});
    mdata[l][w] = d;
    mdirty[l][w] = 0;
    fill = 1; fill_data = d;
    @(posedge clk); #1 fill = 0;
  endtask

  task automatic rd(input string tag, input int l, input int w, input int ws);
    sel(l, w, ws);
    read = 1;
    #1;
    check({tag, "_data"}, read_data, mdata[l][w][ws*32 +: 32]);
    check({tag, "_dirty"}, line_dirty, mdirty[l][w] != 0);
    read = 0;
  endtask

  task automatic flush_start();
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < NW; w++)
        if (mdirty[l][w] != 0) begin
          exq.push_back('{5'(l), 1'(w), mdata[l][w], exp_mask(mdirty[l][w])});
          mdirty[l][w] = 0;
        end
    flush_req = 1;
    @(posedge clk); #1 flush_req = 0;
  endtask

  task automatic wait_flush(input string tag);
    int d0 = done_total;
    int n = 0;
    while (flush_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, flush_busy, 0);
    check({tag, "_done_once"}, done_total - d0, 1);
    check({tag, "_q_empty"}, exq.size(), 0);
  endtask

  initial begin
    int e0, d0;
    logic [63:0] dv;
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < NW; w++) mdirty[l][w] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_evict_valid", evict_valid, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_done", flush_done, 0);
    check("rst_fill_ready", fill_ready, 1);
    check("rst_line_dirty", line_dirty, 0);
    reset = 0;
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < NW; w++) fl(l, w, {$urandom, $urandom, $urandom, $urandom});
    // byte-masked writes and same-cycle reads
    wr(3, 1, 1, 4'b0011, 32'hDEADBEEF, 1);
    sel(3, 1, 1); #1;
    check("t1_lo", read_data[15:0], 16'hBEEF);
    rd("t1", 3, 1, 1);
    wr(7, 0, 3, 4'b1100, 32'h12345678, 1);
    rd("t1b", 7, 0, 3);
    wr(7, 0, 0, 4'b1001, 32'hA5A55A5A, 1);
    rd("t1c", 7, 0, 0);
    stall = 1;
    wr(4, 0, 2, 4'hF, 32'hCAFEF00D, 0);
    stall = 0;
    rd("stall", 4, 0, 2);
    // dirty fill with consumer stalled
    evict_ready = 0;
    fl(3, 1, {$urandom, $urandom, $urandom, $urandom});
    check("t2_valid", evict_valid, 1);
    check("t2_fill_ready", fill_ready, 0);
    check("t2_clean", line_dirty, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_hold_ready", fill_ready, 0);
    check("t3_hold_valid", evict_valid, 1);
    evict_ready = 1;
    @(posedge clk); #1 evict_ready = 0;
    check("t3_ready", fill_ready, 1);
    check("t3_empty", evict_valid, 0);
    check("t3_q", exq.size(), 0);
    evict_ready = 1;
    fl(7, 0, {$urandom, $urandom, $urandom, $urandom});
    @(posedge clk); #1;
    check("t3b_q", exq.size(), 0);
    check("t3b_ready", fill_ready, 1);
    // flush with free-running consumer
    e0 = ev_cnt;
    wr(0, 0, 0, 4'h1, 32'h11111111, 1);
    wr(5, 1, 2, 4'h6, 32'h22222222, 1);
    wr(31, 0, 3, 4'h8, 32'h33333333, 1);
    flush_start();
    wait_flush("t4");
    check("t4_count", ev_cnt - e0, 3);
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < NW; w++) begin
        sel(l, w, 0); #1;
        dv[l*2 + w] = line_dirty;
      end
    check("t4_masks", dv, 0);
    rd("t4", 5, 1, 2);
    // flush with consumer stalled 10 cycles and an ignored core write
    wr(2, 0, 1, 4'h3, 32'h44444444, 1);
    wr(2, 1, 0, 4'hF, 32'h55555555, 1);
    wr(9, 1, 3, 4'h2, 32'h66666666, 1);
    evict_ready = 0;
    e0 = ev_cnt;
    flush_start();
    wr(20, 0, 1, 4'hF, 32'h0BAD0BAD, 0);
    repeat (10) @(posedge clk);
    #1;
    check("t5_hold_valid", evict_valid, 1);
    check("t5_hold_busy", flush_busy, 1);
    check("t5_hold_q", exq.size(), 3);
    evict_ready = 1;
    wait_flush("t5");
    check("t5_count", ev_cnt - e0, 3);
    rd("t5_ign", 20, 0, 1);
    // reset in the middle of a scan
    wr(1, 0, 0, 4'hF, 32'h77777777, 1);
    wr(4, 0, 0, 4'hF, 32'h88888888, 1);
    evict_ready = 0;
    flush_start();
    repeat (20) @(posedge clk);
    #1;
    check("t6_busy", flush_busy, 1);
    d0 = done_total;
    reset = 1;
    #1;
    check("t6_busy_rst", flush_busy, 0);
    check("t6_valid_rst", evict_valid, 0);
    exq.delete();
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < NW; w++) mdirty[l][w] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    evict_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_done", done_total - d0, 0);
    rd("t6", 4, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vx_cache_wb_data.md
Name: vx_cache_wb_data

Overview:
Writeback-capable cache data store for one bank: N-way line storage with per-way, per-byte dirty tracking. Also provides a one-entry eviction buffer with a valid/ready handshake and a hardware flush engine that walks every line/way and emits dirty lines. Sits between the bank tag/MSHR pipeline and the bank's memory-request path; replaces the write-through data store when the bank runs in writeback mode.

Parameters:
CACHE_SIZE, 1024, cache bytes (all banks)
LINE_SIZE, 16, line bytes
NUM_BANKS, 1, bank count
NUM_WAYS, 2, associativity (>=1)
WORD_SIZE, 4, word bytes; WPL = LINE_SIZE/WORD_SIZE
BANK_ID, 0, bank index (trace only)
Derived: LINES = CACHE_SIZE/(LINE_SIZE*NUM_BANKS*NUM_WAYS); LSB = LOG2UP(LINES); WAYB = LOG2UP(NUM_WAYS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  pipeline stall; blocks all core-op state updates
read  in  1  core read
write  in  1  core write (byte-masked word)
fill  in  1  line fill from memory
fill_ready  out  1  fill may be accepted this cycle
line_sel  in  LSB  set index
wsel  in  LOG2UP(WPL)  word index in line
byteen  in  WORD_SIZE  write byte enables
write_data  in  8*WORD_SIZE  core write word
fill_data  in  8*LINE_SIZE  fill line
way_sel  in  NUM_WAYS  one-hot way
read_data  out  8*WORD_SIZE  selected word, same cycle (async-read store)
line_dirty  out  1  addressed line/way has any dirty byte
flush_req  in  1  start flush (sampled in IDLE only)
flush_busy  out  1  flush engine not IDLE
flush_done  out  1  one-cycle pulse at flush completion
evict_valid  out  1  eviction buffer holds a line
evict_ready  in  1  consumer accepts eviction
evict_line_sel  out  LSB  evicted set
evict_way  out  WAYB  evicted way index
evict_data  out  8*LINE_SIZE  evicted line
evict_byteen  out  LINE_SIZE  dirty mask of evicted line

Behaviour:
- Reset (async): all dirty masks 0, evict_valid 0, FSM IDLE, scan counters 0, flush_done 0. Data storage not reset. evict_* payload is don't-care while evict_valid=0.
- Core op accepted when (op && ~stall && ~flush_busy); core ops during flush_busy are ignored, with no state change.
- Priority: fill > write > read. Only one way is written, selected by way_sel.
- write: data bytes at wsel are updated per byteen. dirty[line][way] |= byteen << (wsel*WORD_SIZE).
- fill: requires fill_ready = ~evict_valid. If the victim is dirty, in the same cycle the old line, its dirty mask, set and way load into the eviction buffer and evict_valid is set. The line is then overwritten with fill_data and its dirty mask cleared. A clean victim produces no eviction. A fill issued with fill_ready=0 is a protocol error and is flagged by an assertion.
- Eviction buffer: entry retires on evict_valid && evict_ready. There is no same-cycle refill bypass; fill_ready rises the cycle after retire.
- line_dirty is combinational from the dirty mask at line_sel/way_sel.
- Flush FSM: IDLE -> SCAN on flush_req.
  - SCAN: visit (line, way) from (0,0), way-minor. A clean entry advances the scan. A dirty entry with an empty buffer is loaded into the buffer, its mask is cleared, and the scan advances. A dirty entry with a full buffer holds the scan.
  - After visiting (LINES-1, NUM_WAYS-1): SCAN -> DRAIN.
  - DRAIN -> DONE when evict_valid=0. DONE pulses flush_done for one cycle, then returns to IDLE.
  - Flush ignores stall.
- While flush_busy=1, the storage address is the scan line. Otherwise it is line_sel.
- Reset mid-flush aborts the flush. Dirty state is lost and no flush_done pulse is produced.

Optional Feature:
VX_CACHE_WB_BYTE_DIRTY_EN:
- Defined: dirty tracking is per byte as above, and evict_byteen is the exact mask.
- Undefined: one dirty bit per line/way. evict_byteen is all-ones when the bit is set, and memory stores a full line. Storage for masks shrinks to LINES*NUM_WAYS bits.

Test Plan:
- Write 0xDEADBEEF, byteen=4'b0011, wsel=1, line 3, way 1 -> read_data low half 0xBEEF; line_dirty=1; internal mask 0x0030.
- Fill line 3 way 1 after the previous write -> evict_valid=1, evict_line_sel=3, evict_way=1, evict_byteen=0x0030 (0xFFFF without the feature); line_dirty=0.
- Hold evict_ready=0, attempt a second dirty fill -> fill_ready=0; after one evict_ready pulse, fill_ready=1 the next cycle.
- Dirty sets 0, 5, LINES-1 on mixed ways, flush_req with evict_ready=1 -> exactly 3 evictions in scan order; flush_done once; all masks 0.
- Flush with evict_ready stalled 10 cycles -> scan holds, no eviction is lost or duplicated, and core write during flush_busy has no effect.
- Assert reset mid-SCAN -> flush_busy=0, evict_valid=0 immediately; no flush_done pulse.
